// File: rtl/pong_game_controller.sv
// Pong game-state sequencer: ball, paddles and scores advance once per video
// frame; a serve/play/score/game-over FSM sequences each rally.
module pong_game_controller #(
  parameter int FIELD_X_BEGIN      = 20,
  parameter int FIELD_X_END        = 619,
  parameter int FIELD_Y_BEGIN      = 20,
  parameter int FIELD_Y_END        = 459,
  parameter int BALL_RADIUS        = 4,
  parameter int PADDLE_RADIUS      = 30,
  parameter int PADDLE_THICKNESS   = 6,
  parameter int LEFT_PADDLE_BEGIN  = 30,
  parameter int RIGHT_PADDLE_BEGIN = 603,
  parameter int BALL_SPEED         = 2,
  parameter int PADDLE_SPEED       = 4,
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_FRAMES       = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       left_up,
  input  logic       left_dn,
  input  logic       right_up,
  input  logic       right_dn,
  output logic [9:0] ball_loc_x,
  output logic [9:0] ball_loc_y,
  output logic [9:0] left_paddle_loc,
  output logic [9:0] right_paddle_loc,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} state_t;

  // Reset / serve positions
  localparam logic [9:0] BALL_X0  = 10'd320;
  localparam logic [9:0] BALL_Y0  = 10'd240;
  localparam logic [9:0] PAD_INIT = 10'd240;

  // Paddle travel limits
  localparam logic [9:0] PAD_MIN = 10'(FIELD_Y_BEGIN + PADDLE_RADIUS);
  localparam logic [9:0] PAD_MAX = 10'(FIELD_Y_END - PADDLE_RADIUS);
  localparam logic [9:0] PAD_SPD = 10'(PADDLE_SPEED);

  // Ball geometry, signed so a move past zero never wraps
  localparam logic signed [11:0] BR    = 12'(BALL_RADIUS);
  localparam logic signed [11:0] BSPD  = 12'(BALL_SPEED);
  localparam logic signed [11:0] FXB   = 12'(FIELD_X_BEGIN);
  localparam logic signed [11:0] FXE   = 12'(FIELD_X_END);
  localparam logic signed [11:0] FYB   = 12'(FIELD_Y_BEGIN);
  localparam logic signed [11:0] FYE   = 12'(FIELD_Y_END);
  localparam logic signed [11:0] LFACE = 12'(LEFT_PADDLE_BEGIN + PADDLE_THICKNESS);
  localparam logic signed [11:0] RFACE = 12'(RIGHT_PADDLE_BEGIN);
  localparam logic signed [11:0] REACH = 12'(PADDLE_RADIUS + BALL_RADIUS);

  // Positions the ball is snapped to after a bounce
  localparam logic [9:0] Y_TOP_BOUNCE = 10'(FIELD_Y_BEGIN + BALL_RADIUS + 1);
  localparam logic [9:0] Y_BOT_BOUNCE = 10'(FIELD_Y_END - BALL_RADIUS - 1);
  localparam logic [9:0] X_LEFT_HIT   = 10'(LEFT_PADDLE_BEGIN + PADDLE_THICKNESS + BALL_RADIUS + 1);
  localparam logic [9:0] X_RIGHT_HIT  = 10'(RIGHT_PADDLE_BEGIN - BALL_RADIUS - 1);

  localparam logic [3:0] WIN4       = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

  state_t     state_reg, state_next;
  logic [9:0] ball_x_reg, ball_x_next;
  logic [9:0] ball_y_reg, ball_y_next;
  logic       dx_reg, dx_next;          // 1 = moving toward larger x
  logic       dy_reg, dy_next;          // 1 = moving toward larger y
  logic [9:0] paddle_reg  [2];          // index 0 = left, 1 = right
  logic [9:0] paddle_next [2];
  logic [9:0] paddle_step [2];
  logic [3:0] score_reg   [2];
  logic [3:0] score_next  [2];
  logic       scorer_reg, scorer_next;  // 0 = left scored, 1 = right scored
  logic [7:0] serve_cnt_reg, serve_cnt_next;
  logic       game_over_reg, game_over_next;
  logic       winner_reg, winner_next;

  logic [1:0] btn_up, btn_dn;
  assign btn_up = {right_up, left_up};
  assign btn_dn = {right_dn, left_dn};

  // One button step with clamping; both or neither pressed holds position.
  function automatic logic [9:0] paddle_move(input logic [9:0] loc, input logic up, input logic dn);
    logic [9:0] res;
    res = loc;
    if (up && !dn)
      res = (loc < PAD_MIN + PAD_SPD) ? PAD_MIN : loc - PAD_SPD;
    else if (dn && !up)
      res = (loc > PAD_MAX - PAD_SPD) ? PAD_MAX : loc + PAD_SPD;
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_paddle
      assign paddle_step[gi] = paddle_move(paddle_reg[gi], btn_up[gi], btn_dn[gi]);
    end
  endgenerate

  // Candidate ball move for this frame plus wall and paddle contact tests
  logic signed [11:0] bx, nx, ny, dist_l, dist_r;
  logic [9:0]         y_wall;
  logic               dy_wall, hit_l, hit_r, miss_l, miss_r;
  always_comb begin
    bx      = $signed({2'b00, ball_x_reg});
    nx      = bx + (dx_reg ? BSPD : -BSPD);
    ny      = $signed({2'b00, ball_y_reg}) + (dy_reg ? BSPD : -BSPD);
    y_wall  = ny[9:0];
    dy_wall = dy_reg;
    if (ny - BR <= FYB) begin
      y_wall  = Y_TOP_BOUNCE;
      dy_wall = 1'b1;
    end else if (ny + BR >= FYE) begin
      y_wall  = Y_BOT_BOUNCE;
      dy_wall = 1'b0;
    end
    dist_l = ny - $signed({2'b00, paddle_reg[0]});
    if (dist_l < 0) dist_l = -dist_l;
    dist_r = ny - $signed({2'b00, paddle_reg[1]});
    if (dist_r < 0) dist_r = -dist_r;
    hit_l  = !dx_reg && (bx - BR > LFACE) && (nx - BR <= LFACE) && (dist_l <= REACH);
    hit_r  = dx_reg && (bx + BR < RFACE) && (nx + BR >= RFACE) && (dist_r <= REACH);
    miss_l = (nx - BR <= FXB);
    miss_r = (nx + BR >= FXE);
  end

  // Scorer's next score, saturating at the winning value
  logic [3:0] score_inc;
  always_comb begin
    score_inc = score_reg[scorer_reg];
    if (score_inc != WIN4) score_inc = score_inc + 4'd1;
  end

  // Next-state and datapath updates for the rally sequencer
  always_comb begin
    state_next     = state_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    dx_next        = dx_reg;
    dy_next        = dy_reg;
    paddle_next[0] = paddle_reg[0];
    paddle_next[1] = paddle_reg[1];
    score_next[0]  = score_reg[0];
    score_next[1]  = score_reg[1];
    scorer_next    = scorer_reg;
    serve_cnt_next = serve_cnt_reg;
    game_over_next = game_over_reg;
    winner_next    = winner_reg;
    case (state_reg)
      IDLE: begin
        if (frame_tick && start) begin
          state_next     = SERVE;
          serve_cnt_next = 8'd0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          paddle_next[0] = paddle_step[0];
          paddle_next[1] = paddle_step[1];
          ball_x_next    = BALL_X0;
          ball_y_next    = BALL_Y0;
          if (serve_cnt_reg == SERVE_LAST) state_next = PLAY;
          else serve_cnt_next = serve_cnt_reg + 8'd1;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          paddle_next[0] = paddle_step[0];
          paddle_next[1] = paddle_step[1];
          if (hit_l) begin
            ball_x_next = X_LEFT_HIT;
            dx_next     = 1'b1;
            ball_y_next = y_wall;
            dy_next     = dy_wall;
          end else if (hit_r) begin
            ball_x_next = X_RIGHT_HIT;
            dx_next     = 1'b0;
            ball_y_next = y_wall;
            dy_next     = dy_wall;
          end else if (miss_l) begin
            // ball left at its pre-move position
            state_next  = SCORED;
            scorer_next = 1'b1;
          end else if (miss_r) begin
            state_next  = SCORED;
            scorer_next = 1'b0;
          end else begin
            ball_x_next = nx[9:0];
            ball_y_next = y_wall;
            dy_next     = dy_wall;
          end
        end
      end
      SCORED: begin
        score_next[scorer_reg] = score_inc;
        if (score_inc == WIN4) begin
          state_next     = OVER;
          game_over_next = 1'b1;
          winner_next    = scorer_reg;
        end else begin
          state_next     = SERVE;
          serve_cnt_next = 8'd0;
          ball_x_next    = BALL_X0;
          ball_y_next    = BALL_Y0;
          dx_next        = ~scorer_reg;  // serve toward the player who lost the point
        end
      end
      OVER: begin
        if (frame_tick && start) begin
          state_next     = SERVE;
          serve_cnt_next = 8'd0;
          score_next[0]  = 4'd0;
          score_next[1]  = 4'd0;
          game_over_next = 1'b0;
          dx_next        = 1'b1;
          ball_x_next    = BALL_X0;
          ball_y_next    = BALL_Y0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ball_x_reg    <= BALL_X0;
      ball_y_reg    <= BALL_Y0;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      paddle_reg[0] <= PAD_INIT;
      paddle_reg[1] <= PAD_INIT;
      score_reg[0]  <= 4'd0;
      score_reg[1]  <= 4'd0;
      scorer_reg    <= 1'b0;
      serve_cnt_reg <= 8'd0;
      game_over_reg <= 1'b0;
      winner_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      paddle_reg[0] <= paddle_next[0];
      paddle_reg[1] <= paddle_next[1];
      score_reg[0]  <= score_next[0];
      score_reg[1]  <= score_next[1];
      scorer_reg    <= scorer_next;
      serve_cnt_reg <= serve_cnt_next;
      game_over_reg <= game_over_next;
      winner_reg    <= winner_next;
    end
  end

  assign ball_loc_x       = ball_x_reg;
  assign ball_loc_y       = ball_y_reg;
  assign left_paddle_loc  = paddle_reg[0];
  assign right_paddle_loc = paddle_reg[1];
  assign left_score       = score_reg[0];
  assign right_score      = score_reg[1];
  assign game_over        = game_over_reg;
  assign winner           = winner_reg;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller: plays full rallies from reset to
// game over and restart, checking hand-computed ball/paddle/score values.
module tb_pong_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       left_up = 1'b0, left_dn = 1'b0, right_up = 1'b0, right_dn = 1'b0;
  logic [9:0] ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc;
  logic [3:0] left_score, right_score;
  logic       game_over, winner;

  int vectors = 0;
  int miscompares = 0;

  pong_game_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .left_up(left_up), .left_dn(left_dn), .right_up(right_up), .right_dn(right_dn),
    .ball_loc_x(ball_loc_x), .ball_loc_y(ball_loc_y),
    .left_paddle_loc(left_paddle_loc), .right_paddle_loc(right_paddle_loc),
    .left_score(left_score), .right_score(right_score),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // One frame: a single-cycle tick, then idle cycles so a SCORED step settles
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if ({ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc, left_score, right_score, game_over, winner}
        !== {10'd320, 10'd240, 10'd240, 10'd240, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got ball(%0d,%0d) pad(%0d,%0d) score(%0d,%0d) over=%0b win=%0b want ball(320,240) pad(240,240) score(0,0) over=0 win=0",
               ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc, left_score, right_score, game_over, winner);
    end
    vectors++;
  endtask

  task automatic test_idle();
    left_up = 1'b1; right_dn = 1'b1;
    run_ticks(3);
    left_up = 1'b0; right_dn = 1'b0;
    if ({left_paddle_loc, right_paddle_loc, ball_loc_x, ball_loc_y} !== {10'd240, 10'd240, 10'd320, 10'd240}) begin
      miscompares++;
      $display("FAIL idle_hold: got pad(%0d,%0d) ball(%0d,%0d) want pad(240,240) ball(320,240)",
               left_paddle_loc, right_paddle_loc, ball_loc_x, ball_loc_y);
    end
    vectors++;
  endtask

  // Rally 1 serve: start, paddles clamp, both-buttons hold, serve length
  task automatic test_serve_paddles();
    start = 1'b1;
    tick();                       // IDLE -> SERVE
    left_up = 1'b1; right_dn = 1'b1;
    run_ticks(10);                // start still high: ignored in SERVE
    start = 1'b0;
    run_ticks(37);                // serve tick 47
    if ({left_paddle_loc, right_paddle_loc} !== {10'd52, 10'd428}) begin
      miscompares++;
      $display("FAIL paddle_step47: got (%0d,%0d) want (52,428)", left_paddle_loc, right_paddle_loc);
    end
    vectors++;
    tick();                       // serve tick 48
    if ({left_paddle_loc, right_paddle_loc} !== {10'd50, 10'd429}) begin
      miscompares++;
      $display("FAIL paddle_clamp: got (%0d,%0d) want (50,429)", left_paddle_loc, right_paddle_loc);
    end
    vectors++;
    left_dn = 1'b1; right_up = 1'b1;
    run_ticks(4);                 // serve tick 52
    left_up = 1'b0; left_dn = 1'b0; right_up = 1'b0; right_dn = 1'b0;
    if ({left_paddle_loc, right_paddle_loc} !== {10'd50, 10'd429}) begin
      miscompares++;
      $display("FAIL paddle_both_hold: got (%0d,%0d) want (50,429)", left_paddle_loc, right_paddle_loc);
    end
    vectors++;
    run_ticks(8);                 // serve tick 60 -> PLAY, ball not yet moved
    if ({ball_loc_x, ball_loc_y} !== {10'd320, 10'd240}) begin
      miscompares++;
      $display("FAIL serve_hold: got (%0d,%0d) want (320,240)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    tick();                       // play tick 1
    if ({ball_loc_x, ball_loc_y} !== {10'd322, 10'd242}) begin
      miscompares++;
      $display("FAIL first_move: got (%0d,%0d) want (322,242)", ball_loc_x, ball_loc_y);
    end
    vectors++;
  endtask

  // Rally 1 play: bottom wall bounce, right paddle misses, left scores
  task automatic test_bottom_wall_left_point();
    run_ticks(106);               // k=107
    if (ball_loc_y !== 10'd454) begin
      miscompares++;
      $display("FAIL bottom_approach_y: got %0d want 454", ball_loc_y);
    end
    vectors++;
    tick();                       // k=108 bounce
    if ({ball_loc_x, ball_loc_y} !== {10'd536, 10'd454}) begin
      miscompares++;
      $display("FAIL bottom_bounce: got (%0d,%0d) want (536,454)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    tick();                       // k=109
    if ({ball_loc_x, ball_loc_y} !== {10'd538, 10'd452}) begin
      miscompares++;
      $display("FAIL bottom_rebound: got (%0d,%0d) want (538,452)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    run_ticks(38);                // k=147
    if ({ball_loc_x, left_score} !== {10'd614, 4'd0}) begin
      miscompares++;
      $display("FAIL pre_miss_right: got x=%0d ls=%0d want x=614 ls=0", ball_loc_x, left_score);
    end
    vectors++;
    tick();                       // k=148 miss -> SCORED -> SERVE
    if ({left_score, right_score, ball_loc_x, ball_loc_y} !== {4'd1, 4'd0, 10'd320, 10'd240}) begin
      miscompares++;
      $display("FAIL left_point: got score(%0d,%0d) ball(%0d,%0d) want score(1,0) ball(320,240)",
               left_score, right_score, ball_loc_x, ball_loc_y);
    end
    vectors++;
  endtask

  // Rally 2: top wall, right paddle return, left paddle misses, right scores
  task automatic test_right_paddle_right_point();
    right_up = 1'b1;
    run_ticks(60);
    if (right_paddle_loc !== 10'd189) begin
      miscompares++;
      $display("FAIL right_paddle_serve: got %0d want 189", right_paddle_loc);
    end
    vectors++;
    run_ticks(20);                // k=20
    right_up = 1'b0;
    if (right_paddle_loc !== 10'd109) begin
      miscompares++;
      $display("FAIL right_paddle_play: got %0d want 109", right_paddle_loc);
    end
    vectors++;
    run_ticks(87);                // k=107
    if (ball_loc_y !== 10'd26) begin
      miscompares++;
      $display("FAIL top_approach_y: got %0d want 26", ball_loc_y);
    end
    vectors++;
    tick();                       // k=108
    if (ball_loc_y !== 10'd25) begin
      miscompares++;
      $display("FAIL top_bounce_y: got %0d want 25", ball_loc_y);
    end
    vectors++;
    tick();                       // k=109
    if (ball_loc_y !== 10'd27) begin
      miscompares++;
      $display("FAIL top_rebound_y: got %0d want 27", ball_loc_y);
    end
    vectors++;
    run_ticks(31);                // k=140 right paddle hit
    if ({ball_loc_x, ball_loc_y} !== {10'd598, 10'd89}) begin
      miscompares++;
      $display("FAIL right_hit: got (%0d,%0d) want (598,89)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    tick();                       // k=141
    if ({ball_loc_x, ball_loc_y} !== {10'd596, 10'd91}) begin
      miscompares++;
      $display("FAIL right_return: got (%0d,%0d) want (596,91)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    run_ticks(182);               // k=323 bottom bounce
    if ({ball_loc_x, ball_loc_y} !== {10'd232, 10'd454}) begin
      miscompares++;
      $display("FAIL bottom_bounce2: got (%0d,%0d) want (232,454)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    run_ticks(103);               // k=426, left paddle at 50 missed
    if ({ball_loc_x, right_score} !== {10'd26, 4'd0}) begin
      miscompares++;
      $display("FAIL pre_miss_left: got x=%0d rs=%0d want x=26 rs=0", ball_loc_x, right_score);
    end
    vectors++;
    tick();                       // k=427 miss
    if ({left_score, right_score, ball_loc_x, ball_loc_y} !== {4'd1, 4'd1, 10'd320, 10'd240}) begin
      miscompares++;
      $display("FAIL right_point: got score(%0d,%0d) ball(%0d,%0d) want score(1,1) ball(320,240)",
               left_score, right_score, ball_loc_x, ball_loc_y);
    end
    vectors++;
  endtask

  // Rally 3: serve toward left, left paddle return, right misses
  task automatic test_left_paddle();
    left_dn = 1'b1;
    run_ticks(15);
    left_dn = 1'b0;
    if (left_paddle_loc !== 10'd110) begin
      miscompares++;
      $display("FAIL left_paddle_move: got %0d want 110", left_paddle_loc);
    end
    vectors++;
    run_ticks(46);                // k=1
    if ({ball_loc_x, ball_loc_y} !== {10'd318, 10'd238}) begin
      miscompares++;
      $display("FAIL serve_toward_loser: got (%0d,%0d) want (318,238)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    run_ticks(138);               // k=139
    if ({ball_loc_x, ball_loc_y} !== {10'd42, 10'd87}) begin
      miscompares++;
      $display("FAIL left_approach: got (%0d,%0d) want (42,87)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    tick();                       // k=140 hit
    if ({ball_loc_x, ball_loc_y} !== {10'd41, 10'd89}) begin
      miscompares++;
      $display("FAIL left_hit: got (%0d,%0d) want (41,89)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    tick();                       // k=141
    if ({ball_loc_x, ball_loc_y} !== {10'd43, 10'd91}) begin
      miscompares++;
      $display("FAIL left_return: got (%0d,%0d) want (43,91)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    run_ticks(285);               // k=426
    if ({ball_loc_x, ball_loc_y} !== {10'd613, 10'd248}) begin
      miscompares++;
      $display("FAIL rally3_late: got (%0d,%0d) want (613,248)", ball_loc_x, ball_loc_y);
    end
    vectors++;
    tick();                       // k=427 miss
    if ({left_score, right_score} !== {4'd2, 4'd1}) begin
      miscompares++;
      $display("FAIL rally3_point: got score(%0d,%0d) want (2,1)", left_score, right_score);
    end
    vectors++;
  endtask

  // Rallies 4..10: right paddle parked at 229, left scores each rally to 9
  task automatic test_win();
    for (int r = 4; r <= 10; r++) begin
      if (r == 4) begin
        right_dn = 1'b1;
        run_ticks(30);
        right_dn = 1'b0;
        run_ticks(30);
        if (right_paddle_loc !== 10'd229) begin
          miscompares++;
          $display("FAIL right_paddle_park: got %0d want 229", right_paddle_loc);
        end
        vectors++;
      end else begin
        run_ticks(60);
      end
      run_ticks(147);
      if ({left_score, game_over} !== {4'(r - 2), 1'b0}) begin
        miscompares++;
        $display("FAIL rally%0d_before: got ls=%0d over=%0b want ls=%0d over=0", r, left_score, game_over, r - 2);
      end
      vectors++;
      tick();
      if (r < 10) begin
        if ({left_score, game_over, ball_loc_x, ball_loc_y} !== {4'(r - 1), 1'b0, 10'd320, 10'd240}) begin
          miscompares++;
          $display("FAIL rally%0d_after: got ls=%0d over=%0b ball(%0d,%0d) want ls=%0d over=0 ball(320,240)",
                   r, left_score, game_over, ball_loc_x, ball_loc_y, r - 1);
        end
        vectors++;
      end else begin
        if ({left_score, right_score, game_over, winner, ball_loc_x} !== {4'd9, 4'd1, 1'b1, 1'b0, 10'd614}) begin
          miscompares++;
          $display("FAIL game_over: got score(%0d,%0d) over=%0b win=%0b x=%0d want score(9,1) over=1 win=0 x=614",
                   left_score, right_score, game_over, winner, ball_loc_x);
        end
        vectors++;
      end
    end
    left_up = 1'b1; right_up = 1'b1;
    run_ticks(3);
    left_up = 1'b0; right_up = 1'b0;
    if ({left_paddle_loc, right_paddle_loc, ball_loc_x, left_score, game_over} !== {10'd110, 10'd229, 10'd614, 4'd9, 1'b1}) begin
      miscompares++;
      $display("FAIL over_frozen: got pad(%0d,%0d) x=%0d ls=%0d over=%0b want pad(110,229) x=614 ls=9 over=1",
               left_paddle_loc, right_paddle_loc, ball_loc_x, left_score, game_over);
    end
    vectors++;
  endtask

  task automatic test_restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    if ({left_score, right_score, game_over, ball_loc_x, ball_loc_y} !== {4'd0, 4'd0, 1'b0, 10'd320, 10'd240}) begin
      miscompares++;
      $display("FAIL restart: got score(%0d,%0d) over=%0b ball(%0d,%0d) want score(0,0) over=0 ball(320,240)",
               left_score, right_score, game_over, ball_loc_x, ball_loc_y);
    end
    vectors++;
    run_ticks(61);
    if ({ball_loc_x, ball_loc_y} !== {10'd322, 10'd242}) begin
      miscompares++;
      $display("FAIL restart_serve_dir: got (%0d,%0d) want (322,242)", ball_loc_x, ball_loc_y);
    end
    vectors++;
  endtask

  task automatic test_reset_mid_play();
    run_ticks(2);
    @(negedge clk);
    frame_tick = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if ({ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc, left_score, right_score, game_over, winner}
        !== {10'd320, 10'd240, 10'd240, 10'd240, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_play: got ball(%0d,%0d) pad(%0d,%0d) score(%0d,%0d) over=%0b win=%0b want reset values",
               ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc, left_score, right_score, game_over, winner);
    end
    vectors++;
    reset = 1'b0;
    run_ticks(2);
    if ({ball_loc_x, ball_loc_y} !== {10'd320, 10'd240}) begin
      miscompares++;
      $display("FAIL idle_after_reset: got (%0d,%0d) want (320,240)", ball_loc_x, ball_loc_y);
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_serve_paddles();
    test_bottom_wall_left_point();
    test_right_paddle_right_point();
    test_left_paddle();
    test_win();
    test_restart();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
